// File: rtl/tube_pkg.sv
// Shared segment encodings and helpers for the multiplexed seven-segment tube driver.
package tube_pkg;

  localparam logic [7:0] SEG_0     = 8'hFC;
  localparam logic [7:0] SEG_1     = 8'h60;
  localparam logic [7:0] SEG_2     = 8'hDA;
  localparam logic [7:0] SEG_3     = 8'hF2;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'hB6;
  localparam logic [7:0] SEG_6     = 8'hBE;
  localparam logic [7:0] SEG_7     = 8'hE0;
  localparam logic [7:0] SEG_8     = 8'hFE;
  localparam logic [7:0] SEG_9     = 8'hF6;
  localparam logic [7:0] SEG_A     = 8'hEE;
  localparam logic [7:0] SEG_B     = 8'h3E;
  localparam logic [7:0] SEG_C     = 8'h9C;
  localparam logic [7:0] SEG_D     = 8'h7A;
  localparam logic [7:0] SEG_E     = 8'h9E;
  localparam logic [7:0] SEG_F     = 8'h8E;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Bit positions on the segment bus {a,b,c,d,e,f,g,dp}.
  localparam int SEG_BIT_A  = 7;
  localparam int SEG_BIT_B  = 6;
  localparam int SEG_BIT_C  = 5;
  localparam int SEG_BIT_D  = 4;
  localparam int SEG_BIT_E  = 3;
  localparam int SEG_BIT_F  = 2;
  localparam int SEG_BIT_G  = 1;
  localparam int SEG_BIT_DP = 0;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble);
    case (nibble)
      4'h0:    hex_to_seg = SEG_0;
      4'h1:    hex_to_seg = SEG_1;
      4'h2:    hex_to_seg = SEG_2;
      4'h3:    hex_to_seg = SEG_3;
      4'h4:    hex_to_seg = SEG_4;
      4'h5:    hex_to_seg = SEG_5;
      4'h6:    hex_to_seg = SEG_6;
      4'h7:    hex_to_seg = SEG_7;
      4'h8:    hex_to_seg = SEG_8;
      4'h9:    hex_to_seg = SEG_9;
      4'hA:    hex_to_seg = SEG_A;
      4'hB:    hex_to_seg = SEG_B;
      4'hC:    hex_to_seg = SEG_C;
      4'hD:    hex_to_seg = SEG_D;
      4'hE:    hex_to_seg = SEG_E;
      4'hF:    hex_to_seg = SEG_F;
      default: hex_to_seg = SEG_BLANK;
    endcase
  endfunction

  // Counter width for a modulus, never narrower than one bit.
  function automatic int count_width(input int modulus);
    count_width = (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

endpackage

// File: rtl/tube_scan_timer.sv
// Per-digit dwell timer and digit index; flags the last cycle of every frame.
module tube_scan_timer
  import tube_pkg::*;
#(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 50000,
  localparam int IDX_W   = count_width(DIGITS),
  localparam int CNT_W   = count_width(SCAN_DIV)
) (
  input  logic             clk,
  input  logic             reset,
  output logic [IDX_W-1:0] idx,
  output logic             tick,
  output logic             boundary
);

  logic [CNT_W-1:0] cnt_r;
  logic [IDX_W-1:0] idx_r;

  assign tick     = (cnt_r == CNT_W'(SCAN_DIV - 1));
  assign boundary = tick && (idx_r == IDX_W'(DIGITS - 1));
  assign idx      = idx_r;

  // Dwell counter and digit index, both wrapping at their moduli.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
      idx_r <= '0;
    end else if (tick) begin
      cnt_r <= '0;
      if (boundary) begin
        idx_r <= '0;
      end else begin
        idx_r <= idx_r + IDX_W'(1);
      end
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tube_scanner.sv
// Multiplexed seven-segment driver with frame-synchronous loading, decimal
// points, per-digit blinking and optional leading-zero blanking.
module tube_scanner
  import tube_pkg::*;
#(
  parameter int DIGITS       = 8,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4*DIGITS-1:0] data_in,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic [DIGITS-1:0]   blink_in,
  input  logic                data_valid,
  input  logic                lz_blank,
  output logic [DIGITS-1:0]   tube_scan,
  output logic [7:0]          tube_signal,
  output logic                frame_done
);

  localparam int IDX_W = count_width(DIGITS);
  localparam int FRM_W = count_width(BLINK_FRAMES);

  logic [IDX_W-1:0]    idx_s;
  logic                tick_s;
  logic                boundary_s;
  logic                frame_end_s;

  logic [4*DIGITS-1:0] pend_data_r;
  logic [DIGITS-1:0]   pend_dp_r;
  logic [DIGITS-1:0]   pend_blink_r;
  logic                pend_flag_r;
  logic [4*DIGITS-1:0] shadow_data_r;
  logic [DIGITS-1:0]   shadow_dp_r;
  logic [DIGITS-1:0]   shadow_blink_r;

  logic [FRM_W-1:0]    frm_cnt_r;
  logic                phase_r;

  logic [3:0]          nib_s [DIGITS];
  logic [DIGITS-1:0]   zero_above_s;
  logic [DIGITS-1:0]   scan_s;
  logic [7:0]          seg_s;

  tube_scan_timer #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .idx      (idx_s),
    .tick     (tick_s),
    .boundary (boundary_s)
  );

  assign frame_end_s = tick_s && boundary_s;

  // Pending/shadow pair: shadow only ever changes on the frame boundary edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_data_r    <= '0;
      pend_dp_r      <= '0;
      pend_blink_r   <= '0;
      pend_flag_r    <= 1'b0;
      shadow_data_r  <= '0;
      shadow_dp_r    <= '0;
      shadow_blink_r <= '0;
    end else if (frame_end_s) begin
      if (data_valid) begin
        shadow_data_r  <= data_in;
        shadow_dp_r    <= dp_in;
        shadow_blink_r <= blink_in;
      end else if (pend_flag_r) begin
        shadow_data_r  <= pend_data_r;
        shadow_dp_r    <= pend_dp_r;
        shadow_blink_r <= pend_blink_r;
      end
      pend_flag_r <= 1'b0;
    end else if (data_valid) begin
      pend_data_r  <= data_in;
      pend_dp_r    <= dp_in;
      pend_blink_r <= blink_in;
      pend_flag_r  <= 1'b1;
    end
  end

  // Blink phase flips every BLINK_FRAMES frames, aligned with the shadow commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      frm_cnt_r <= '0;
      phase_r   <= 1'b1;
    end else if (frame_end_s && (BLINK_FRAMES > 0)) begin
      if (frm_cnt_r == FRM_W'(BLINK_FRAMES - 1)) begin
        frm_cnt_r <= '0;
        phase_r   <= ~phase_r;
      end else begin
        frm_cnt_r <= frm_cnt_r + FRM_W'(1);
      end
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    assign nib_s[g]        = shadow_data_r[4*g +: 4];
    assign zero_above_s[g] = (shadow_data_r[4*DIGITS-1:4*g] == '0);
    assign scan_s[g]       = (idx_s != IDX_W'(g));
  end

  // Segment pattern for the digit currently selected by the timer.
  always_comb begin
    seg_s = SEG_BLANK;
    if (shadow_blink_r[idx_s] && !phase_r) begin
      seg_s = SEG_BLANK;
    end else begin
      if (lz_blank && (idx_s != '0) && zero_above_s[idx_s]) begin
        seg_s = SEG_BLANK;
      end else begin
        seg_s = hex_to_seg(nib_s[idx_s]);
      end
      seg_s[SEG_BIT_DP] = shadow_dp_r[idx_s];
    end
  end

  // Output registers; they trail the digit index by one clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      tube_scan   <= '1;
      tube_signal <= SEG_BLANK;
      frame_done  <= 1'b0;
    end else begin
      tube_scan   <= scan_s;
      tube_signal <= seg_s;
      frame_done  <= frame_end_s;
    end
  end

endmodule

// File: tb/tb_tube_scanner.sv
// Directed bench for tube_scanner with 4 digits, 4-cycle dwell, 2-frame blink.
module tb_tube_scanner;

  localparam int DIGITS       = 4;
  localparam int SCAN_DIV     = 4;
  localparam int BLINK_FRAMES = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] data_in = 16'h0000;
  logic [3:0]  dp_in = 4'b0000;
  logic [3:0]  blink_in = 4'b0000;
  logic        data_valid = 1'b0;
  logic        lz_blank = 1'b0;
  logic [3:0]  tube_scan;
  logic [7:0]  tube_signal;
  logic        frame_done;

  int errs = 0;
  int checks = 0;
  int nfd = 0;

  always #5 clk = ~clk;

  // Counts frame_done pulses so the blink phase can be predicted.
  always @(negedge clk) begin
    if (frame_done === 1'b1) nfd <= nfd + 1;
  end

  tube_scanner #(
    .DIGITS       (DIGITS),
    .SCAN_DIV     (SCAN_DIV),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .data_in     (data_in),
    .dp_in       (dp_in),
    .blink_in    (blink_in),
    .data_valid  (data_valid),
    .lz_blank    (lz_blank),
    .tube_scan   (tube_scan),
    .tube_signal (tube_signal),
    .frame_done  (frame_done)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] scan_of(input int d);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << d);
  endfunction

  // Starts in a frame_done cycle; checks one full frame and ends on the next one.
  task automatic run_frame(input string tag, input logic [31:0] exp);
    for (int d = 0; d < 4; d++) begin
      step(1);
      check_eq($sformatf("%s_d%0d_scan", tag, d), {28'd0, tube_scan}, {28'd0, scan_of(d)});
      check_eq($sformatf("%s_d%0d_seg", tag, d), {24'd0, tube_signal}, {24'd0, exp[8*d +: 8]});
      step(3);
    end
    check_eq($sformatf("%s_fd", tag), {31'd0, frame_done}, 32'd1);
  endtask

  // Free-running frame from reset release: scan order, FC everywhere, one pulse.
  task automatic scan_after_reset(input string tag);
    for (int k = 0; k < 16; k++) begin
      step(1);
      check_eq($sformatf("%s_k%0d_scan", tag, k), {28'd0, tube_scan}, {28'd0, scan_of(k / 4)});
      check_eq($sformatf("%s_k%0d_seg", tag, k), {24'd0, tube_signal}, 32'h0000_00FC);
      check_eq($sformatf("%s_k%0d_fd", tag, k), {31'd0, frame_done}, (k == 15) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [7:0] exp0;

    step(3);
    check_eq("rst_scan", {28'd0, tube_scan}, 32'h0000_000F);
    check_eq("rst_seg", {24'd0, tube_signal}, 32'h0000_0000);
    check_eq("rst_fd", {31'd0, frame_done}, 32'd0);
    reset = 1'b0;

    scan_after_reset("scan1");
    scan_after_reset("scan2");

    // Load mid-frame at idx=1; the old value must hold until the frame ends.
    step(5);
    data_in = 16'h12AF;
    data_valid = 1'b1;
    step(1);
    data_valid = 1'b0;
    step(3);
    check_eq("sync_old_d2", {24'd0, tube_signal}, 32'h0000_00FC);
    step(4);
    check_eq("sync_old_d3", {24'd0, tube_signal}, 32'h0000_00FC);
    step(3);
    check_eq("sync_fd", {31'd0, frame_done}, 32'd1);
    run_frame("sync_new", 32'h60DA_EE8E);

    // Two strobes in one frame: last wins.
    step(2);
    data_in = 16'h3333;
    data_valid = 1'b1;
    step(1);
    data_valid = 1'b0;
    step(6);
    check_eq("two_old_d2", {24'd0, tube_signal}, 32'h0000_00DA);
    data_in = 16'h4567;
    data_valid = 1'b1;
    step(1);
    data_valid = 1'b0;
    step(6);
    check_eq("two_fd", {31'd0, frame_done}, 32'd1);
    run_frame("two_new", 32'h66B6_BEE0);

    // Strobe exactly on the boundary cycle goes straight to the shadow.
    step(15);
    data_in = 16'h0005;
    data_valid = 1'b1;
    step(1);
    data_valid = 1'b0;
    check_eq("byp_fd", {31'd0, frame_done}, 32'd1);
    run_frame("byp", 32'hFCFC_FCB6);

    // Leading-zero blanking with a decimal point on the top digit.
    data_in = 16'h0050;
    dp_in = 4'b1000;
    lz_blank = 1'b1;
    data_valid = 1'b1;
    step(1);
    data_valid = 1'b0;
    step(15);
    check_eq("lz_fd", {31'd0, frame_done}, 32'd1);
    run_frame("lz_on", 32'h0100_B6FC);
    lz_blank = 1'b0;
    run_frame("lz_off", 32'hFDFC_B6FC);

    // Blink digit 0; phase follows the number of boundaries since reset.
    data_in = 16'h0008;
    dp_in = 4'b0000;
    blink_in = 4'b0001;
    data_valid = 1'b1;
    step(1);
    data_valid = 1'b0;
    step(15);
    check_eq("blink_fd", {31'd0, frame_done}, 32'd1);
    for (int f = 0; f < 4; f++) begin
      n = nfd + 1;
      exp0 = (((n / 2) % 2) == 0) ? 8'hFE : 8'h00;
      run_frame($sformatf("blink_f%0d", f), {24'hFCFCFC, exp0});
    end

    // Reset while a load is pending at idx=2; the pending data must be lost.
    blink_in = 4'b0000;
    data_in = 16'h9999;
    step(8);
    data_valid = 1'b1;
    step(1);
    data_valid = 1'b0;
    reset = 1'b1;
    step(1);
    check_eq("mid_rst_scan", {28'd0, tube_scan}, 32'h0000_000F);
    check_eq("mid_rst_seg", {24'd0, tube_signal}, 32'h0000_0000);
    check_eq("mid_rst_fd", {31'd0, frame_done}, 32'd0);
    reset = 1'b0;
    scan_after_reset("post_rst");
    run_frame("post_rst_f1", 32'hFCFC_FCFC);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/tube_scanner.md
# tube_scanner

Parametrised multiplexed seven-segment display driver: the successor to the fixed eight-digit hex tube driver. It time-multiplexes a DIGITS-wide hex value onto a shared segment bus, with an active-low digit select. It adds tear-free frame-synchronous data loading, per-digit decimal points, per-digit blinking, and optional leading-zero blanking. It sits between the CPU's display MMIO register and the board's tube pins.

## Interface
- DIGITS, 8, number of digits driven (1..16)
- SCAN_DIV, 50000, clk cycles each digit is lit (≥2)
- BLINK_FRAMES, 64, full scan frames per blink half-period; 0 disables blinking
- clk  input  1  system clock (100 MHz)
- reset  input  1  synchronous, active-high reset
- data_in  input  4*DIGITS  hex nibbles; nibble i is shown on digit i
- dp_in  input  DIGITS  decimal-point enable per digit
- blink_in  input  DIGITS  blink enable per digit
- data_valid  input  1  load strobe; always accepted, no ready signal
- lz_blank  input  1  leading-zero blanking mode, sampled live
- tube_scan  output  DIGITS  digit select, active low, one-hot-zero
- tube_signal  output  8  segments {a,b,c,d,e,f,g,dp}, active high
- frame_done  output  1  one-cycle pulse at the start of each frame

## Operation
- Scan timer `cnt` runs 0..SCAN_DIV-1. At SCAN_DIV-1 it wraps to 0 and digit index `idx` advances; `idx` wraps from DIGITS-1 to 0.
- Frame boundary: the cycle with idx==DIGITS-1 and cnt==SCAN_DIV-1.
- Three registers hold data: pending (data, dp, blink), shadow (displayed), and pend_flag.
  - data_valid loads pending and sets pend_flag. Later strobes overwrite pending; the last one wins.
  - At a frame boundary with pend_flag set, shadow←pending and pend_flag clears.
  - If data_valid is high on the boundary cycle, data_in/dp_in/blink_in go straight to shadow and pend_flag clears.
  - Shadow never changes mid-frame.
- Blink: a frame counter counts 0..BLINK_FRAMES-1 and toggles `phase` on wrap. While phase==0, digits with shadow blink bit set are fully blanked (segments and dp = 0).
- Leading-zero blanking (lz_blank=1): digit i>0 shows no a–g segments when nibbles i..DIGITS-1 of shadow are all zero. Its dp is still shown if set. Digit 0 is never blanked.
- Segment codes (a..g, dp=0): 0=FC 1=60 2=DA 3=F2 4=66 5=B6 6=BE 7=E0 8=FE 9=F6 A=EE B=3E C=9C D=7A E=9E F=8E. dp ORs in bit 0.
- tube_scan has bit idx low and all other bits high.

## Timing
- Reset values:
  - cnt=0, idx=0, phase=1 (visible), frame counter=0
  - shadow=0, pending=0, pend_flag=0
  - tube_scan=all ones, tube_signal=8'h00, frame_done=0
- tube_scan and tube_signal are registered from idx/shadow/phase, so they lag idx by 1 cycle. The first clk after reset release drives digit 0.
- frame_done is high for exactly the cycle in which idx has just become 0 after a boundary.
- Load latency: a data_valid pulse is visible on digit 0 one cycle after the next frame_done, at most DIGITS*SCAN_DIV+1 cycles later.
- Each digit is held for exactly SCAN_DIV cycles, so a frame lasts DIGITS*SCAN_DIV cycles.
- The phase toggle takes effect on the same boundary edge as the shadow commit.
- Reset asserted mid-frame returns all state to reset values on that edge. A pending load is discarded.

## Structure
- Package tube_pkg:
  - 16 segment-code constants and the blank code 8'h00
  - segment bit-order constants
  - function hex_to_seg(nibble)
- Sub-module tube_scan_timer: holds cnt/idx/boundary generation, parameters DIGITS and SCAN_DIV, outputs idx, boundary, tick.
- Top: pending/shadow registers, blink counter, blanking logic, output registers. Expected size is about 200 RTL lines.

## Test plan
- Reset/scan, DIGITS=4, SCAN_DIV=4: after reset tube_scan steps 1110→1101→1011→0111→1110, each held for 4 cycles. frame_done pulses every 16 cycles. All digits show FC.
- Load sync: pulse data_valid with data_in=16'h12AF mid-frame, at idx=1. The old value 0 persists to the end of the frame. The next frame shows digit0=8E, 1=EE, 2=DA, 3=60. Two strobes in one frame: only the second value appears.
- Boundary bypass: data_valid with 16'h0005 on the boundary cycle. Digit 0 shows B6 in the very next frame.
- Leading zeros: lz_blank=1, data 16'h0050, dp_in=4'b1000. Digits show 3=01, 2=00, 1=B6, 0=FC. With lz_blank=0, digit 2 shows FC and digit 3 shows FD.
- Blink: BLINK_FRAMES=2, blink_in=4'b0001, data 16'h0008. Digit 0 shows FE for 2 frames, then 00 for 2 frames, repeating. Digits 1..3 are unaffected.
- Reset mid-operation: assert reset while pend_flag=1 at idx=2. Outputs return to all-ones/00, and the pending data never appears.
